// File: rtl/bloom_filter_unit.sv
// bloom_filter_unit: Bloom-filter coprocessor. It supports insert, check and
// clear on DataWidth-bit keys and holds an internal NumBits-bit flop array.
// The hash functions are applied one per cycle.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   req_valid_i/req_ready_o   request handshake (ready only in IDLE)
//   req_op_i, req_data_i      op (00 ins, 01 chk, 10 clr, 11 reserved), key
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_match_o, rsp_err_o    check result, reserved-op flag
//   busy_o                    FSM not in IDLE
//   insert_cnt_o              saturating insert count since last clear/reset
module bloom_filter_unit #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumBits    = 1024,
    parameter int unsigned NumHashes  = 3,
    parameter int unsigned ClearWidth = 32,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_match_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  insert_cnt_o
);
    localparam int unsigned IdxW     = $clog2(NumBits);
    localparam int unsigned IdxSelW  = $clog2(IdxW);
    localparam int unsigned DSelW    = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam int unsigned KW       = 4;
    localparam int unsigned NumWords = NumBits / ClearWidth;
    localparam int unsigned PW       = (NumWords > 1) ? $clog2(NumWords) : 1;

    typedef enum logic [2:0] {IDLE, INSERT, CHECK, CLEAR, RESP} state_e;

    state_e                 state_q;
    logic [NumBits-1:0]     filter_q;
    logic [DataWidth-1:0]   key_q;
    logic [KW-1:0]          k_q;
    logic [PW-1:0]          ptr_q;
    logic [IdxW-1:0]        cur_idx;
    logic [IdxW-1:0]        clr_base;

    // Hash k: rotate key left by 5k, XOR with a golden-ratio multiple, then fold
    // the result into IdxW bits by XORing consecutive chunks.
    function automatic logic [IdxW-1:0] hash_idx(input logic [DataWidth-1:0] key,
                                                 input logic [KW-1:0] k);
        logic [2*DataWidth-1:0] dbl;
        logic [DataWidth-1:0]   x;
        logic [31:0]            kc;
        logic [DataWidth+31:0]  kext;
        logic [IdxW-1:0]        idx;
        int unsigned            amt;
        amt  = (32'd5 * 32'(k)) % DataWidth;
        dbl  = {key, key} << amt;
        kc   = 32'h9E3779B9 * (32'(k) + 32'd1);
        kext = {{DataWidth{1'b0}}, kc};
        x    = dbl[2*DataWidth-1:DataWidth] ^ kext[DataWidth-1:0];
        idx  = '0;
        for (int unsigned i = 0; i < DataWidth; i++) begin
            idx[IdxSelW'(i % IdxW)] = idx[IdxSelW'(i % IdxW)] ^ x[DSelW'(i)];
        end
        return idx;
    endfunction

    assign cur_idx  = hash_idx(key_q, k_q);
    assign clr_base = IdxW'(32'(ptr_q) * ClearWidth);

    // Control FSM, array updates and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            filter_q     <= '0;
            key_q        <= '0;
            k_q          <= '0;
            ptr_q        <= '0;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_match_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
            busy_o       <= 1'b0;
            insert_cnt_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        key_q       <= req_data_i;
                        k_q         <= '0;
                        ptr_q       <= '0;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        case (req_op_i)
                            2'b00:   state_q <= INSERT;
                            2'b01:   state_q <= CHECK;
                            2'b10:   state_q <= CLEAR;
                            default: begin
                                state_q     <= RESP;
                                rsp_valid_o <= 1'b1;
                                rsp_match_o <= 1'b0;
                                rsp_err_o   <= 1'b1;
                            end
                        endcase
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                INSERT: begin
                    filter_q[cur_idx] <= 1'b1;
                    if (k_q == KW'(NumHashes - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_match_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        if (insert_cnt_o != {CntWidth{1'b1}}) begin
                            insert_cnt_o <= insert_cnt_o + CntWidth'(1);
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                CHECK: begin
                    // Early exit on the first clear bit.
                    if (!filter_q[cur_idx] || k_q == KW'(NumHashes - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_match_o <= filter_q[cur_idx];
                        rsp_err_o   <= 1'b0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                CLEAR: begin
                    filter_q[clr_base +: ClearWidth] <= '0;
                    if (ptr_q == PW'(NumWords - 1)) begin
                        state_q      <= RESP;
                        rsp_valid_o  <= 1'b1;
                        rsp_match_o  <= 1'b0;
                        rsp_err_o    <= 1'b0;
                        insert_cnt_o <= '0;
                    end else begin
                        ptr_q <= ptr_q + PW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bloom_filter_unit.sv
module tb_bloom_filter_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_match;
    logic        rsp_err;
    logic        busy;
    logic [15:0] insert_cnt;

    int unsigned n_vec;
    int unsigned n_bad;

    // Reference state: the filter as a plain bit vector plus insert count.
    bit [1023:0] mvec;
    int unsigned mcnt;

    bloom_filter_unit dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_match_o(rsp_match), .rsp_err_o(rsp_err),
        .busy_o(busy), .insert_cnt_o(insert_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Bit-by-bit rotation and repeated 10-bit folding (defaults only).
    function automatic int unsigned m_hash(input bit [31:0] key, input int k);
        bit [31:0] x;
        int unsigned idx;
        int amt;
        amt = (5 * k) % 32;
        for (int i = 0; i < 32; i++) x[(i + amt) % 32] = key[i];
        x = x ^ (32'h9E3779B9 * 32'(k + 1));
        idx = 0;
        while (x != 0) begin
            idx = idx ^ (x & 32'h3FF);
            x = x >> 10;
        end
        return idx;
    endfunction

    // Issue one op, check latency and response, stall for 'stall' cycles.
    task automatic do_op(input logic [1:0] op, input logic [31:0] key, input int stall,
                         output int lat, output logic got_match);
        int elat;
        logic emat;
        logic eerr;
        int unsigned ecnt;
        int w;
        elat = 0; emat = 1'b0; eerr = 1'b0; ecnt = mcnt;
        case (op)
            2'b00: begin elat = 3; ecnt = (mcnt == 32'hFFFF) ? mcnt : mcnt + 1; end
            2'b01: begin
                elat = 3; emat = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    if (!mvec[m_hash(key, k)]) begin elat = k + 1; emat = 1'b0; break; end
                end
            end
            2'b10: begin elat = 32; ecnt = 0; end
            default: begin elat = 0; eerr = 1'b1; end
        endcase
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_data = key;
        @(posedge clk);
        if (op == 2'b00) for (int k = 0; k < 3; k++) mvec[m_hash(key, k)] = 1'b1;
        if (op == 2'b10) mvec = '0;
        mcnt = ecnt;
        @(negedge clk);
        // Junk on the request lines must be ignored while busy.
        req_op = 2'($urandom_range(0, 3)); req_data = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            chk("busy_wait", 32'(busy), 32'd1);
            chk("ready_wait", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("match", 32'(rsp_match), 32'(emat));
        chk("err", 32'(rsp_err), 32'(eerr));
        chk("cnt", 32'(insert_cnt), ecnt);
        chk("ready_resp", 32'(req_ready), 32'd0);
        got_match = rsp_match;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_match", 32'(rsp_match), 32'(emat));
            chk("stall_err", 32'(rsp_err), 32'(eerr));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("array", 32'(dut.filter_q == mvec), 32'd1);
    endtask

    initial begin
        int lat;
        logic m;
        logic [31:0] pool [8];
        logic [31:0] saved_key;
        int r;
        n_vec = 0; n_bad = 0; mvec = '0; mcnt = 0;
        req_valid = 1'b0; req_op = 2'b00; req_data = '0; rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("model_hash0", m_hash(32'h0, 0), 32'd390);
        #20;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(insert_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        do_op(2'b01, 32'h0, 0, lat, m);
        chk("empty_check_lat", 32'(lat), 32'd1);
        chk("empty_check_match", 32'(m), 32'd0);
        do_op(2'b00, 32'h0, 0, lat, m);
        chk("ins0_lat", 32'(lat), 32'd3);
        chk("ins0_bit390", 32'(dut.filter_q[390]), 32'd1);
        chk("ins0_cnt", 32'(insert_cnt), 32'd1);
        do_op(2'b01, 32'h0, 0, lat, m);
        chk("chk0_lat", 32'(lat), 32'd3);
        chk("chk0_match", 32'(m), 32'd1);

        do_op(2'b00, 32'hDEADBEEF, 0, lat, m);
        do_op(2'b01, 32'hDEADBEEF, 0, lat, m);
        chk("dead_match", 32'(m), 32'd1);
        do_op(2'b10, 32'h0, 0, lat, m);
        chk("clear_lat", 32'(lat), 32'd32);
        chk("clear_cnt", 32'(insert_cnt), 32'd0);
        do_op(2'b01, 32'hDEADBEEF, 0, lat, m);
        chk("dead_after_clear", 32'(m), 32'd0);

        do_op(2'b00, 32'h12345678, 10, lat, m);
        do_op(2'b11, 32'hCAFEF00D, 2, lat, m);
        chk("resv_lat", 32'(lat), 32'd0);
        chk("resv_cnt", 32'(insert_cnt), 32'd1);

        // Randomized mix over a small key pool so checks often hit.
        for (int i = 0; i < 8; i++) pool[i] = $urandom;
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            do_op((r < 45) ? 2'b00 : (r < 88) ? 2'b01 : (r < 94) ? 2'b10 : 2'b11,
                  (r % 5 == 0) ? $urandom : pool[$urandom_range(0, 7)],
                  $urandom_range(0, 3), lat, m);
        end

        // Reset in the middle of a clear sweep.
        saved_key = 32'hA5A5F00F;
        do_op(2'b00, saved_key, 0, lat, m);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_data = '0;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_cnt", 32'(insert_cnt), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_array", 32'(dut.filter_q == '0), 32'd1);
        mvec = '0; mcnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
        chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        do_op(2'b01, saved_key, 0, lat, m);
        chk("mid_rst_check", 32'(m), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bloom_filter_unit.md
Name: bloom_filter_unit

Overview:
- Parametrised Bloom-filter coprocessor for the custom-instruction path.
- Accepts insert, check and clear operations on DataWidth-bit keys (typically RS1 data) over a valid/ready request channel and returns a match result over a valid/ready response channel.
- Hashes are applied sequentially, one per cycle, against an internal NumBits-bit flop array.
- Clear is a word-wise sweep, so no single-cycle wide reset path is needed at runtime.

Parameters:
- DataWidth, 32: key width in bits.
- NumBits, 1024: filter array size; power of two, minimum 64. IdxW = log2(NumBits).
- NumHashes, 3: number of hash functions, 1..8.
- ClearWidth, 32: bits cleared per cycle during clear; power of two, must divide NumBits.
- CntWidth, 16: width of the insert counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid&ready
- req_op_i  input  2  00 insert, 01 check, 10 clear, 11 reserved
- req_data_i  input  DataWidth  key
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed when valid&ready
- rsp_match_o  output  1  check result: 1 = all hashed bits set
- rsp_err_o  output  1  1 = reserved op
- busy_o  output  1  FSM not in IDLE
- insert_cnt_o  output  CntWidth  saturating count of completed inserts since last clear/reset

Behaviour:
- Reset (async, rst_ni=0):
  - FSM to IDLE; all array bits 0.
  - insert_cnt_o=0, rsp_valid_o=0, rsp_match_o=0, rsp_err_o=0, busy_o=0.
  - req_ready_o=0 while in reset, 1 after reset deasserts.
- Hash k (k=0..NumHashes-1):
  - X = rotl(key, (5*k) mod DataWidth) XOR K_k.
  - K_k = low DataWidth bits of 32'h9E3779B9*(k+1); zero-extended if DataWidth>32.
  - index_k = XOR of consecutive IdxW-bit chunks of X from bit 0 upward; the last partial chunk is zero-padded.
- FSM states: IDLE, INSERT, CHECK, CLEAR, RESP.
- req_ready_o=1 only in IDLE. On accept, latch op and key, set hash counter k=0, then:
  - insert -> INSERT
  - check -> CHECK
  - clear -> CLEAR with sweep pointer 0
  - reserved -> RESP directly with rsp_err_o=1, rsp_match_o=0
- INSERT:
  - Each cycle sets bit index_k and increments k.
  - After k=NumHashes-1, go to RESP with rsp_match_o=0 and insert_cnt_o incremented (saturates at all-ones).
  - Latency: NumHashes cycles from accept to rsp_valid_o.
- CHECK:
  - Each cycle reads bit index_k.
  - Bit 0: go to RESP immediately with match=0 (early exit).
  - Bit 1 and k=NumHashes-1: go to RESP with match=1.
  - Latency: 1..NumHashes cycles.
- CLEAR:
  - Each cycle zeroes bits [ptr*ClearWidth +: ClearWidth] and increments ptr.
  - After the last word (NumBits/ClearWidth cycles), set insert_cnt_o=0 and go to RESP with match=0.
- RESP:
  - rsp_valid_o=1; rsp_match_o and rsp_err_o held stable until rsp_ready_i=1.
  - On handshake, go to IDLE; rsp_valid_o drops the next cycle.
  - No request is accepted in the handshake cycle (one bubble).
- The array is updated only by the FSM; no overlapping operations.
- Duplicate hash indices within one insert are harmless (bit re-set).
- busy_o = (state != IDLE).
- Request inputs are ignored outside IDLE.
- Reset mid-operation aborts the operation immediately: array cleared, no response issued.

Test Plan:
- After reset with defaults (DataWidth=32, NumBits=1024, NumHashes=3), check key 0 -> rsp_match_o=0 one cycle after accept (early exit at k=0); rsp_err_o=0; insert_cnt_o=0.
- Insert key 0 -> rsp_valid_o 3 cycles after accept; array bit 390 (index_0 of key 0, 0x186) set; insert_cnt_o=1. Then check key 0 -> match=1 after 3 cycles.
- Insert 0xDEADBEEF, check 0xDEADBEEF -> match=1. Then clear -> response after 32 cycles, insert_cnt_o=0. Check 0xDEADBEEF -> match=0.
- Hold rsp_ready_i=0 for 10 cycles after an insert -> rsp_valid_o and outputs stable, req_ready_o=0. Release -> single handshake, req_ready_o=1 the following cycle.
- req_op_i=11 -> response the next cycle with rsp_err_o=1, match=0; array and counter unchanged.
- Assert rst_ni=0 during cycle 10 of a clear -> all outputs at reset values asynchronously, no response. After release, check of a previously inserted key -> match=0.
